// File: rtl/mem_stage_sram_ctrl.sv
// Memory pipeline stage: splits 32-bit loads/stores into two 16-bit SRAM accesses with fixed
// wait states, stalls upstream via ready, and holds the MEM/WB pipeline register.
module mem_stage_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_enable,
  input  logic               mem_read_enable,
  input  logic               mem_write_enable,
  input  logic [3:0]         dest,
  input  logic [31:0]        alu_out,
  input  logic [31:0]        Val_Rm,
  output logic               ready,
  output logic               wb_enable_out,
  output logic               mem_read_enable_out,
  output logic [3:0]         dest_out,
  output logic [31:0]        alu_out_q,
  output logic [31:0]        mem_data_out,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_out,
  input  logic [15:0]        SRAM_DQ_in,
  output logic               SRAM_WE_N
);

  localparam int unsigned   CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [15:0]        lo_half;
  logic [15:0]        hi_half;
  logic               req;
  logic               is_load;
  logic               phase_last;
  logic [SRAM_AW-2:0] word;

  always_comb begin
    req        = mem_read_enable | mem_write_enable;
    // A simultaneous read+write request is treated as a store only.
    is_load    = mem_read_enable & ~mem_write_enable;
    phase_last = (cnt == CNT_LAST);
    word       = (SRAM_AW-1)'((alu_out - 32'(ADDR_BASE)) >> 2);
    ready      = (!req && (state == IDLE || rst)) || (state == DONE);
  end

  // SRAM pins are registered and set up on the edge entering each phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      SRAM_WE_N   <= 1'b1;
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= '0;
      lo_half     <= '0;
      hi_half     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state       <= LO;
            cnt         <= '0;
            SRAM_ADDR   <= {word, 1'b0};
            SRAM_WE_N   <= ~mem_write_enable;
            SRAM_DQ_out <= mem_write_enable ? Val_Rm[15:0] : '0;
          end
        end
        LO: begin
          if (phase_last) begin
            lo_half     <= SRAM_DQ_in;
            state       <= HI;
            cnt         <= '0;
            SRAM_ADDR   <= {word, 1'b1};
            SRAM_WE_N   <= ~mem_write_enable;
            SRAM_DQ_out <= mem_write_enable ? Val_Rm[31:16] : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HI: begin
          if (phase_last) begin
            hi_half     <= SRAM_DQ_in;
            state       <= DONE;
            cnt         <= '0;
            SRAM_ADDR   <= '0;
            SRAM_WE_N   <= 1'b1;
            SRAM_DQ_out <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // MEM/WB register: a stalled cycle inserts a bubble so write-back fires exactly once.
  always_ff @(posedge clk) begin
    if (rst || !ready) begin
      wb_enable_out       <= 1'b0;
      mem_read_enable_out <= 1'b0;
      dest_out            <= '0;
      alu_out_q           <= '0;
      mem_data_out        <= '0;
    end else begin
      wb_enable_out       <= wb_enable;
      mem_read_enable_out <= is_load;
      dest_out            <= dest;
      alu_out_q           <= alu_out;
      mem_data_out        <= is_load ? {hi_half, lo_half} : '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Testbench for mem_stage_sram_ctrl: SRAM model with 3-cycle access, shadow memory reference
// model and per-cycle expected traces derived from phase lengths.
module tb_mem_stage_sram_ctrl;

  localparam int unsigned P       = 3;          // phase length = WAIT_CYCLES + 1
  localparam int unsigned MEM_CYC = 2 * P + 2;  // request cycle + two phases + DONE
  localparam int unsigned MAX_CYC = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_enable = 1'b0;
  logic        mem_read_enable = 1'b0;
  logic        mem_write_enable = 1'b0;
  logic [3:0]  dest = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] Val_Rm = '0;
  logic        ready;
  logic        wb_enable_out;
  logic        mem_read_enable_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_out_q;
  logic [31:0] mem_data_out;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic [15:0] SRAM_DQ_in;
  logic        SRAM_WE_N;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(2), .ADDR_BASE(1024), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .wb_enable(wb_enable), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .dest(dest), .alu_out(alu_out), .Val_Rm(Val_Rm),
    .ready(ready), .wb_enable_out(wb_enable_out), .mem_read_enable_out(mem_read_enable_out),
    .dest_out(dest_out), .alu_out_q(alu_out_q), .mem_data_out(mem_data_out),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // SRAM model: write on any edge with WE_N low; read data valid once the address has been
  // stable for P cycles, junk before that.
  logic [15:0] sram_mem [int];
  logic [15:0] model_mem [int];
  int          age = 0;
  logic [17:0] age_addr = '0;
  logic [15:0] sram_rd = 16'hA5A5;
  assign SRAM_DQ_in = sram_rd;

  always @(posedge clk) begin
    if (!SRAM_WE_N) sram_mem[int'(SRAM_ADDR)] = SRAM_DQ_out;
  end

  always @(negedge clk) begin
    if (SRAM_ADDR == age_addr) age = age + 1;
    else age = 1;
    age_addr = SRAM_ADDR;
    if (age < int'(P)) sram_rd = 16'hA5A5;
    else if (sram_mem.exists(int'(SRAM_ADDR))) sram_rd = sram_mem[int'(SRAM_ADDR)];
    else sram_rd = 16'h0000;
  end

  // Trace of one instruction, sampled at each negedge until ready is seen high.
  logic        tr_ready [0:63];
  logic [17:0] tr_addr  [0:63];
  logic        tr_we    [0:63];
  logic [15:0] tr_dq    [0:63];
  logic        tr_wb    [0:63];
  logic [3:0]  tr_dest  [0:63];
  int          n_cyc;
  logic [69:0] res;

  function automatic int haddr(input logic [31:0] alu, input int half);
    logic [31:0] off;
    off = alu - 32'd1024;
    return int'((off / 32'd4) % 32'd131072) * 2 + half;
  endfunction

  function automatic logic [15:0] model_rd(input int a);
    if (model_mem.exists(a)) return model_mem[a];
    return 16'h0000;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] alu);
    return {model_rd(haddr(alu, 1)), model_rd(haddr(alu, 0))};
  endfunction

  // Expected {ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_out} in cycle k after presentation.
  function automatic logic [35:0] exp_trace(input logic mem, input logic wr,
                                            input logic [31:0] alu, input logic [31:0] rm,
                                            input int k);
    int          ph;
    logic        r;
    logic [17:0] a;
    logic        we;
    logic [15:0] d;
    r  = mem ? (k == int'(2 * P + 1)) : 1'b1;
    ph = 0;
    if (mem && k >= 1 && k <= int'(P)) ph = 1;
    if (mem && k > int'(P) && k <= int'(2 * P)) ph = 2;
    a  = (ph == 0) ? 18'h0 : 18'(haddr(alu, ph - 1));
    we = !(ph != 0 && wr);
    d  = (ph != 0 && wr) ? ((ph == 1) ? rm[15:0] : rm[31:16]) : 16'h0;
    return {r, a, we, d};
  endfunction

  function automatic logic [35:0] obs_trace(input int k);
    return {tr_ready[k], tr_addr[k], tr_we[k], tr_dq[k]};
  endfunction

  function automatic logic [69:0] exp_res(input logic wbe, input logic rd, input logic wr,
                                          input logic [3:0] dst, input logic [31:0] alu);
    logic ld;
    ld = rd & ~wr;
    return {wbe, ld, dst, alu, ld ? model_word(alu) : 32'h0};
  endfunction

  // Entered and left at posedge+1; result captured after the edge that saw ready=1.
  task automatic drive_op(input logic rd, input logic wr, input logic wbe,
                          input logic [3:0] dst, input logic [31:0] alu, input logic [31:0] rm);
    logic done;
    mem_read_enable  = rd;
    mem_write_enable = wr;
    wb_enable        = wbe;
    dest             = dst;
    alu_out          = alu;
    Val_Rm           = rm;
    n_cyc = 0;
    done  = 1'b0;
    while (!done && n_cyc < int'(MAX_CYC)) begin
      @(negedge clk);
      tr_ready[n_cyc] = ready;
      tr_addr[n_cyc]  = SRAM_ADDR;
      tr_we[n_cyc]    = SRAM_WE_N;
      tr_dq[n_cyc]    = SRAM_DQ_out;
      tr_wb[n_cyc]    = wb_enable_out;
      tr_dest[n_cyc]  = dest_out;
      done  = ready;
      n_cyc = n_cyc + 1;
      @(posedge clk);
      #1;
    end
    res = {wb_enable_out, mem_read_enable_out, dest_out, alu_out_q, mem_data_out};
  endtask

  task automatic model_store(input logic [31:0] alu, input logic [31:0] rm);
    model_mem[haddr(alu, 0)] = rm[15:0];
    model_mem[haddr(alu, 1)] = rm[31:16];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ_out} !== {1'b1, 1'b1, 18'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset_sram: got %h expected %h",
               {ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ_out}, {1'b1, 1'b1, 18'h0, 16'h0});
    end
    checks++;
    if ({wb_enable_out, mem_read_enable_out, dest_out, alu_out_q, mem_data_out} !== 70'h0) begin
      failures++;
      $display("FAIL reset_memwb: got %h expected 0",
               {wb_enable_out, mem_read_enable_out, dest_out, alu_out_q, mem_data_out});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_store;
    drive_op(1'b0, 1'b1, 1'b0, 4'd0, 32'd1028, 32'hDEADBEEF);
    checks++;
    if (n_cyc !== int'(MEM_CYC)) begin
      failures++;
      $display("FAIL store_cycles: got %0d expected %0d", n_cyc, MEM_CYC);
    end
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (obs_trace(k) !== exp_trace(1'b1, 1'b1, 32'd1028, 32'hDEADBEEF, k)) begin
        failures++;
        $display("FAIL store_trace[%0d]: got %h expected %h", k, obs_trace(k),
                 exp_trace(1'b1, 1'b1, 32'd1028, 32'hDEADBEEF, k));
      end
      checks++;
      if (tr_wb[k] !== 1'b0) begin
        failures++;
        $display("FAIL store_wb[%0d]: got %b expected 0", k, tr_wb[k]);
      end
    end
    checks++;
    if (res[69:68] !== 2'b00) begin
      failures++;
      $display("FAIL store_result_en: got %b expected 00", res[69:68]);
    end
    model_store(32'd1028, 32'hDEADBEEF);
  endtask

  task automatic test_load;
    drive_op(1'b1, 1'b0, 1'b1, 4'd5, 32'd1028, 32'h0);
    checks++;
    if (n_cyc !== int'(MEM_CYC)) begin
      failures++;
      $display("FAIL load_cycles: got %0d expected %0d", n_cyc, MEM_CYC);
    end
    checks++;
    if (res !== {1'b1, 1'b1, 4'd5, 32'd1028, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL load_result: got %h expected %h", res,
               {1'b1, 1'b1, 4'd5, 32'd1028, 32'hDEADBEEF});
    end
    drive_op(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    checks++;
    if ({tr_wb[0], res[69]} !== 2'b10) begin
      failures++;
      $display("FAIL load_wb_pulse: got %b expected 10", {tr_wb[0], res[69]});
    end
  endtask

  task automatic test_nonmem;
    drive_op(1'b0, 1'b0, 1'b1, 4'd3, 32'h12345678, 32'hCAFEF00D);
    checks++;
    if ({n_cyc, obs_trace(0)} !== {32'd1, exp_trace(1'b0, 1'b0, 32'h12345678, 32'h0, 0)}) begin
      failures++;
      $display("FAIL nonmem_trace: got cycles=%0d %h expected cycles=1 %h", n_cyc, obs_trace(0),
               exp_trace(1'b0, 1'b0, 32'h12345678, 32'h0, 0));
    end
    checks++;
    if ({res, SRAM_WE_N} !== {1'b1, 1'b0, 4'd3, 32'h12345678, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL nonmem_result: got %h expected %h", {res, SRAM_WE_N},
               {1'b1, 1'b0, 4'd3, 32'h12345678, 32'h0, 1'b1});
    end
  endtask

  task automatic test_reset_mid_store;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b1;
    wb_enable        = 1'b0;
    dest             = 4'd0;
    alu_out          = 32'd1424;
    Val_Rm           = $urandom;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (SRAM_WE_N !== 1'b0) begin
      failures++;
      $display("FAIL abort_mid_store: got WE_N=%b expected 0", SRAM_WE_N);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_write_enable = 1'b0;
    alu_out = 32'h0;
    Val_Rm  = 32'h0;
    @(negedge clk);
    checks++;
    if ({ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ_out, wb_enable_out, mem_read_enable_out, dest_out,
         alu_out_q, mem_data_out} !== {1'b1, 1'b1, 104'h0}) begin
      failures++;
      $display("FAIL abort_state: got %h expected %h",
               {ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ_out, wb_enable_out, mem_read_enable_out,
                dest_out, alu_out_q, mem_data_out}, {1'b1, 1'b1, 104'h0});
    end
    @(posedge clk);
    #1;
    drive_op(1'b1, 1'b0, 1'b1, 4'd6, 32'd1028, 32'h0);
    checks++;
    if ({n_cyc, res} !== {MEM_CYC, exp_res(1'b1, 1'b1, 1'b0, 4'd6, 32'd1028)}) begin
      failures++;
      $display("FAIL abort_then_load: got cycles=%0d %h expected cycles=%0d %h", n_cyc, res,
               MEM_CYC, exp_res(1'b1, 1'b1, 1'b0, 4'd6, 32'd1028));
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rm;
    rm = $urandom;
    drive_op(1'b0, 1'b1, 1'b0, 4'd0, 32'h0, rm);
    checks++;
    if ({tr_addr[1], tr_addr[P + 1]} !== {18'h3FE00, 18'h3FE01}) begin
      failures++;
      $display("FAIL wrap_addr: got %h %h expected 3fe00 3fe01", tr_addr[1], tr_addr[P + 1]);
    end
    model_store(32'h0, rm);
    drive_op(1'b1, 1'b0, 1'b1, 4'd1, 32'h0, 32'h0);
    checks++;
    if (res[31:0] !== rm) begin
      failures++;
      $display("FAIL wrap_readback: got %h expected %h", res[31:0], rm);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] rm;
    rm = $urandom;
    drive_op(1'b1, 1'b1, 1'b1, 4'd9, 32'd1032, rm);
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (obs_trace(k) !== exp_trace(1'b1, 1'b1, 32'd1032, rm, k)) begin
        failures++;
        $display("FAIL illegal_trace[%0d]: got %h expected %h", k, obs_trace(k),
                 exp_trace(1'b1, 1'b1, 32'd1032, rm, k));
      end
    end
    checks++;
    if ({n_cyc, res} !== {MEM_CYC, 1'b1, 1'b0, 4'd9, 32'd1032, 32'h0}) begin
      failures++;
      $display("FAIL illegal_result: got cycles=%0d %h expected cycles=%0d %h", n_cyc, res,
               MEM_CYC, {1'b1, 1'b0, 4'd9, 32'd1032, 32'h0});
    end
    model_store(32'd1032, rm);
    drive_op(1'b1, 1'b0, 1'b1, 4'd9, 32'd1032, 32'h0);
    checks++;
    if (res[31:0] !== rm) begin
      failures++;
      $display("FAIL illegal_readback: got %h expected %h", res[31:0], rm);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] alu2;
    alu2 = $urandom;
    drive_op(1'b1, 1'b0, 1'b1, 4'd7, 32'd1028, 32'h0);
    checks++;
    if ({n_cyc, res} !== {MEM_CYC, exp_res(1'b1, 1'b1, 1'b0, 4'd7, 32'd1028)}) begin
      failures++;
      $display("FAIL b2b_load: got cycles=%0d %h expected cycles=%0d %h", n_cyc, res, MEM_CYC,
               exp_res(1'b1, 1'b1, 1'b0, 4'd7, 32'd1028));
    end
    for (int k = 1; k < n_cyc; k++) begin
      checks++;
      if (tr_wb[k] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_bubble[%0d]: got %b expected 0", k, tr_wb[k]);
      end
    end
    drive_op(1'b0, 1'b0, 1'b1, 4'd2, alu2, 32'h0);
    checks++;
    if ({n_cyc, tr_wb[0], tr_dest[0], res} !==
        {32'd1, 1'b1, 4'd7, 1'b1, 1'b0, 4'd2, alu2, 32'h0}) begin
      failures++;
      $display("FAIL b2b_next: got %h expected %h", {n_cyc, tr_wb[0], tr_dest[0], res},
               {32'd1, 1'b1, 4'd7, 1'b1, 1'b0, 4'd2, alu2, 32'h0});
    end
    drive_op(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    checks++;
    if ({tr_dest[0], res[69]} !== {4'd2, 1'b0}) begin
      failures++;
      $display("FAIL b2b_tail: got %h expected %h", {tr_dest[0], res[69]}, {4'd2, 1'b0});
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int          op;
      logic        rd;
      logic        wr;
      logic        mem;
      logic        wbe;
      logic [3:0]  dst;
      logic [31:0] alu;
      logic [31:0] rm;
      logic [69:0] er;
      op  = int'($urandom_range(0, 2));
      rd  = (op == 1);
      wr  = (op == 2);
      mem = rd | wr;
      wbe = 1'($urandom);
      dst = 4'($urandom);
      rm  = $urandom;
      alu = mem ? 32'(1024 + 4 * $urandom_range(0, 15)) : $urandom;
      er  = exp_res(wbe, rd, wr, dst, alu);
      drive_op(rd, wr, wbe, dst, alu, rm);
      checks++;
      if (n_cyc !== (mem ? int'(MEM_CYC) : 1)) begin
        failures++;
        $display("FAIL rand_cycles[%0d]: got %0d expected %0d", i, n_cyc,
                 mem ? int'(MEM_CYC) : 1);
      end
      for (int k = 0; k < n_cyc; k++) begin
        checks++;
        if (obs_trace(k) !== exp_trace(mem, wr, alu, rm, k)) begin
          failures++;
          $display("FAIL rand_trace[%0d][%0d]: got %h expected %h", i, k, obs_trace(k),
                   exp_trace(mem, wr, alu, rm, k));
        end
        if (k > 0) begin
          checks++;
          if (tr_wb[k] !== 1'b0) begin
            failures++;
            $display("FAIL rand_bubble[%0d][%0d]: got %b expected 0", i, k, tr_wb[k]);
          end
        end
      end
      checks++;
      if (res !== er) begin
        failures++;
        $display("FAIL rand_result[%0d]: got %h expected %h", i, res, er);
      end
      if (wr) model_store(alu, rm);
    end
  endtask

  initial begin
    test_reset;
    test_store;
    test_load;
    test_nonmem;
    test_reset_mid_store;
    test_wrap;
    test_illegal;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
